feistel_f_seq: RTL and testbench
================================

FEISTEL_F_SEQ -- requirements
Module: feistel_f_seq

Interface
REQ-001 SHALL have parameter SBOX_LAT, default 1, giving the S-box ROM read latency in cycles; legal values are 1 and 2.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  in  1  r_in/k_in valid.
REQ-005 SHALL have port in_ready  out  1  block can accept an operand.
REQ-006 SHALL have port r_in  in  32  right half R, bit i = FIPS 46-3 bit i+1.
REQ-007 SHALL have port k_in  in  48  round subkey, bit i = FIPS bit i+1.
REQ-008 SHALL have port sbox_req  out  1  ROM read strobe.
REQ-009 SHALL have port sbox_sel  out  3  S-box number 0..7 (S1..S8).
REQ-010 SHALL have port sbox_addr  out  6  raw 6-bit S-box input.
REQ-011 SHALL have port sbox_data  in  4  ROM result, valid SBOX_LAT cycles after sbox_req.
REQ-012 SHALL have port out_valid  out  1  f_out valid.
REQ-013 SHALL have port out_ready  in  1  consumer accepts f_out.
REQ-014 SHALL have port f_out  out  32  f(R,K), bit i = FIPS bit i+1.
REQ-015 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-017 SHALL drive in_ready=1 only in IDLE; an operand is accepted on a rising edge where in_valid&in_ready.
REQ-018 On accept, SHALL register x = E(r_in) XOR k_in using the existing 32->48 expansion function, then enter RUN.
REQ-019 In RUN, SHALL issue exactly 8 reads, one per cycle, on the 8 consecutive cycles after accept: sbox_req=1, sbox_sel=k, sbox_addr[5:0] = {x[6k],x[6k+1],x[6k+2],x[6k+3],x[6k+4],x[6k+5]} (first FIPS bit is MSB); k=0..7.
REQ-020 SHALL capture the sbox_data returned for read k into s[4k..4k+3], with sbox_data[3] -> s[4k] and sbox_data[0] -> s[4k+3].
REQ-021 SHALL drive sbox_req=0, sbox_sel=0 and sbox_addr=0 whenever no read is issued.
REQ-022 After the final capture, SHALL enter DONE with f_out[i] = s[P[i]-1], where P is the FIPS 46-3 P-permutation table, and assert out_valid.
REQ-023 Latency: for an accept at cycle T, out_valid SHALL first be high in cycle T+9+SBOX_LAT (T+10 at default).
REQ-024 In DONE, out_valid and f_out SHALL hold stable until out_valid&out_ready; the FSM then returns to IDLE.
REQ-025 A new operand SHALL NOT be accepted in the same cycle as the output handshake; in_ready rises the following cycle.
REQ-026 f_out SHALL retain its last result after the handshake until the next entry to DONE.
REQ-027 in_valid SHALL be ignored outside IDLE, and out_ready SHALL be ignored outside DONE.
REQ-028 sbox_data SHALL be sampled only on the expected capture cycles; its value at all other times has no effect.

Reset
REQ-029 While rst=1, SHALL force state IDLE, in_ready=1, out_valid=0, busy=0, sbox_req=0, sbox_sel=0, sbox_addr=0, f_out=0, and clear x, s and the read counter.
REQ-030 Reset asserted mid-RUN or in DONE SHALL abort the operation with no partial output; after release, the first accept SHALL behave exactly as in REQ-018 to REQ-023.

Verification
REQ-031 FIPS vector, SBOX_LAT=1, out_ready=1, with a behavioural ROM holding the FIPS S-tables (hex below is written FIPS bit 1 first; the bench maps FIPS bit 1 to index 0): R=F0AAF0AA, K=1B02EFFC7072 -> first read sel=0, addr=6'b011000, data=4'b0101; f_out=234AA9BB at cycle T+10; one out_valid pulse.
REQ-032 Same vector with SBOX_LAT=2 -> identical f_out, out_valid first high at T+11.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and f_out stay stable; on the out_ready=1 cycle the handshake completes; in_ready=0 that cycle and 1 the next.
REQ-034 Hold in_valid=1 with changing r_in during RUN -> no additional accept; the result matches the operand captured at T.
REQ-035 Assert rst during the 4th read -> all outputs take their reset values immediately; after release, the FIPS vector gives 234AA9BB at the nominal latency.
REQ-036 R=00000000, K=000000000000 -> all 8 reads use addr=0; f_out equals P applied to the concatenated row-0/col-0 S-box entries (checked against the reference model).

Source files
------------

// File: rtl/feistel_f_seq.sv
// DES round function f(R,K), S-box lookups serialised through one external ROM; result 9+SBOX_LAT cycles after accept.
// One operand in flight: in_ready only in IDLE, result held in DONE until out_ready.
module feistel_f_seq #(
    parameter int SBOX_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] r_in,
    input  logic [47:0] k_in,
    output logic        sbox_req,
    output logic [2:0]  sbox_sel,
    output logic [5:0]  sbox_addr,
    input  logic [3:0]  sbox_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] f_out,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Tables are zero-based: entry j is the source bit index (FIPS bit n lives at index n-1).
    localparam logic [4:0] E_IDX [48] = '{
        5'd31, 5'd0,  5'd1,  5'd2,  5'd3,  5'd4,
        5'd3,  5'd4,  5'd5,  5'd6,  5'd7,  5'd8,
        5'd7,  5'd8,  5'd9,  5'd10, 5'd11, 5'd12,
        5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16,
        5'd15, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20,
        5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd24,
        5'd23, 5'd24, 5'd25, 5'd26, 5'd27, 5'd28,
        5'd27, 5'd28, 5'd29, 5'd30, 5'd31, 5'd0
    };

    localparam logic [4:0] P_IDX [32] = '{
        5'd15, 5'd6,  5'd19, 5'd20, 5'd28, 5'd11, 5'd27, 5'd16,
        5'd0,  5'd14, 5'd22, 5'd25, 5'd4,  5'd17, 5'd30, 5'd9,
        5'd1,  5'd7,  5'd23, 5'd13, 5'd31, 5'd26, 5'd2,  5'd8,
        5'd18, 5'd12, 5'd29, 5'd5,  5'd21, 5'd10, 5'd3,  5'd24
    };

    function automatic logic [47:0] expand(input logic [31:0] r);
        logic [47:0] e;
        for (int j = 0; j < 48; j++) e[j] = r[E_IDX[j]];
        return e;
    endfunction

    function automatic logic [31:0] pperm(input logic [31:0] s);
        logic [31:0] p;
        for (int i = 0; i < 32; i++) p[i] = s[P_IDX[i]];
        return p;
    endfunction

    state_t      state, state_nxt;
    logic [47:0] x;
    logic [31:0] s, s_next;
    logic [3:0]  rd_cnt;
    logic [2:0]  cap_cnt;
    logic        req_d1, req_d2;
    logic        cap_vld, cap_en, load_x, done_ld;
    logic [5:0]  x_base;
    logic [5:0]  chunk;

    // x_base = 6*rd_cnt, built from shifts to keep the arithmetic at 6 bits
    assign x_base  = {1'b0, rd_cnt[2:0], 2'b00} + {2'b00, rd_cnt[2:0], 1'b0};
    assign chunk   = x[x_base +: 6];
    assign cap_vld = (SBOX_LAT == 2) ? req_d2 : req_d1;

    // ROM nibble is MSB-first in FIPS order, so it lands bit-reversed in s
    always_comb begin
        s_next = s;
        s_next[{cap_cnt, 2'b00} +: 4] = {sbox_data[0], sbox_data[1], sbox_data[2], sbox_data[3]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        sbox_req  = 1'b0;
        sbox_sel  = 3'd0;
        sbox_addr = 6'd0;
        load_x    = 1'b0;
        cap_en    = 1'b0;
        done_ld   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    load_x    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!rd_cnt[3]) begin
                    sbox_req  = 1'b1;
                    sbox_sel  = rd_cnt[2:0];
                    sbox_addr = {chunk[0], chunk[1], chunk[2], chunk[3], chunk[4], chunk[5]};
                end
                cap_en = cap_vld;
                if (cap_vld && cap_cnt == 3'd7) begin
                    done_ld   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x       <= '0;
            s       <= '0;
            rd_cnt  <= '0;
            cap_cnt <= '0;
            req_d1  <= 1'b0;
            req_d2  <= 1'b0;
            f_out   <= '0;
        end else begin
            req_d1 <= sbox_req;
            req_d2 <= req_d1;
            if (load_x) begin
                x       <= expand(r_in) ^ k_in;
                rd_cnt  <= '0;
                cap_cnt <= '0;
            end else if (sbox_req) begin
                rd_cnt <= rd_cnt + 4'd1;
            end
            if (cap_en) begin
                s       <= s_next;
                cap_cnt <= cap_cnt + 3'd1;
            end
            if (done_ld) f_out <= pperm(s_next);
        end
    end

endmodule

// File: tb/tb_feistel_f_seq.sv
// Directed bench for feistel_f_seq: one instance per legal ROM latency, each fed by a behavioural FIPS S-box ROM.
module tb_feistel_f_seq;

    logic        clk, rst;
    logic        in_valid1, in_ready1, sbox_req1, out_valid1, out_ready1, busy1;
    logic [31:0] r_in1, f_out1;
    logic [47:0] k_in1;
    logic [2:0]  sbox_sel1;
    logic [5:0]  sbox_addr1;
    logic [3:0]  sbox_data1;
    logic        in_valid2, in_ready2, sbox_req2, out_valid2, out_ready2, busy2;
    logic [31:0] r_in2, f_out2;
    logic [47:0] k_in2;
    logic [2:0]  sbox_sel2;
    logic [5:0]  sbox_addr2;
    logic [3:0]  sbox_data2, rom2_a;

    int cmp = 0;
    int mis = 0;
    int n;
    logic [31:0] fips_r, fips_f, zero_f;
    logic [47:0] fips_k;

    int e_tab [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                       16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    int p_tab [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                       2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    int sb [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    feistel_f_seq #(.SBOX_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .r_in(r_in1), .k_in(k_in1), .sbox_req(sbox_req1), .sbox_sel(sbox_sel1),
        .sbox_addr(sbox_addr1), .sbox_data(sbox_data1), .out_valid(out_valid1),
        .out_ready(out_ready1), .f_out(f_out1), .busy(busy1)
    );

    feistel_f_seq #(.SBOX_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .r_in(r_in2), .k_in(k_in2), .sbox_req(sbox_req2), .sbox_sel(sbox_sel2),
        .sbox_addr(sbox_addr2), .sbox_data(sbox_data2), .out_valid(out_valid2),
        .out_ready(out_ready2), .f_out(f_out2), .busy(busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] sb_lookup(input logic [2:0] sel, input logic [5:0] a);
        int row, col;
        row = int'({a[5], a[0]});
        col = int'(a[4:1]);
        return 4'(sb[sel][row * 16 + col]);
    endfunction

    // Off-request cycles return random junk so mistimed sampling shows up in the result.
    always @(posedge clk) begin
        sbox_data1 <= sbox_req1 ? sb_lookup(sbox_sel1, sbox_addr1) : 4'($urandom);
        rom2_a     <= sbox_req2 ? sb_lookup(sbox_sel2, sbox_addr2) : 4'($urandom);
        sbox_data2 <= rom2_a;
    end

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] o;
        for (int i = 0; i < 32; i++) o[i] = v[31 - i];
        return o;
    endfunction

    function automatic logic [47:0] rev48(input logic [47:0] v);
        logic [47:0] o;
        for (int i = 0; i < 48; i++) o[i] = v[47 - i];
        return o;
    endfunction

    function automatic logic [31:0] ref_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s, f;
        logic [5:0]  a;
        logic [3:0]  v;
        for (int j = 0; j < 48; j++) x[j] = r[e_tab[j] - 1] ^ k[j];
        for (int b = 0; b < 8; b++) begin
            for (int j = 0; j < 6; j++) a[5 - j] = x[6 * b + j];
            v = sb_lookup(3'(b), a);
            for (int j = 0; j < 4; j++) s[4 * b + j] = v[3 - j];
        end
        for (int i = 0; i < 32; i++) f[i] = s[p_tab[i] - 1];
        return f;
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        cmp++;
        assert (obs === exp) else begin
            mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Call at a falling edge; n = rising edges until out_valid is seen.
    task automatic wait_vld1(output int cnt);
        cnt = 0;
        while (!out_valid1 && cnt < 40) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic wait_vld2(output int cnt);
        cnt = 0;
        while (!out_valid2 && cnt < 40) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid1 = 1'b0; r_in1 = '0; k_in1 = '0; out_ready1 = 1'b1;
        in_valid2 = 1'b0; r_in2 = '0; k_in2 = '0; out_ready2 = 1'b1;
        fips_r = rev32(32'hF0AAF0AA);
        fips_k = rev48(48'h1B02EFFC7072);
        fips_f = rev32(32'h234AA9BB);
        zero_f = ref_f(32'd0, 48'd0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 48'(in_ready1), 48'(1));
        chk("rst_out_valid", 48'(out_valid1), 48'(0));
        chk("rst_busy", 48'(busy1), 48'(0));
        chk("rst_rom_if", 48'({sbox_req1, sbox_sel1, sbox_addr1}), 48'(0));
        chk("rst_f_out", 48'(f_out1), 48'(0));
        chk("rst_f_out2", 48'(f_out2), 48'(0));
        rst = 1'b0;

        // FIPS vector, out_ready held high
        @(posedge clk); #1;
        in_valid1 = 1'b1; r_in1 = fips_r; k_in1 = fips_k;
        @(posedge clk); #1;
        in_valid1 = 1'b0; r_in1 = '0; k_in1 = '0;
        @(negedge clk);
        chk("run_busy", 48'(busy1), 48'(1));
        chk("run_in_ready", 48'(in_ready1), 48'(0));
        chk("read0", 48'({sbox_req1, sbox_sel1, sbox_addr1}), 48'({1'b1, 3'd0, 6'b011000}));
        @(posedge clk);
        @(negedge clk);
        chk("read0_data", 48'(sbox_data1), 48'(4'b0101));
        chk("read1", 48'({sbox_req1, sbox_sel1, sbox_addr1}), 48'({1'b1, 3'd1, 6'b010001}));
        wait_vld1(n);
        chk("fips_latency", 48'(1 + n), 48'(9));
        chk("fips_f_out", 48'(f_out1), 48'(fips_f));
        @(posedge clk);
        @(negedge clk);
        chk("pulse_out_valid", 48'(out_valid1), 48'(0));
        chk("pulse_in_ready", 48'(in_ready1), 48'(1));
        chk("f_out_retained", 48'(f_out1), 48'(fips_f));

        // in_valid held with changing operands during RUN, then backpressure in DONE
        out_ready1 = 1'b0;
        in_valid1 = 1'b1; r_in1 = fips_r; k_in1 = fips_k;
        @(posedge clk); #1;
        r_in1 = ~fips_r;
        @(negedge clk);
        n = 0;
        while (!out_valid1 && n < 40) begin
            r_in1 = $urandom;
            k_in1 = {16'($urandom), $urandom};
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("hold_latency", 48'(n), 48'(9));
        chk("hold_f_out", 48'(f_out1), 48'(fips_f));
        chk("done_in_ready", 48'(in_ready1), 48'(0));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_out_valid", 48'(out_valid1), 48'(1));
            chk("bp_f_out", 48'(f_out1), 48'(fips_f));
        end
        in_valid1 = 1'b0;
        out_ready1 = 1'b1;
        #1;
        chk("hs_in_ready", 48'(in_ready1), 48'(0));
        chk("hs_out_valid", 48'(out_valid1), 48'(1));
        @(posedge clk);
        @(negedge clk);
        chk("post_hs_in_ready", 48'(in_ready1), 48'(1));
        chk("post_hs_out_valid", 48'(out_valid1), 48'(0));
        @(posedge clk);
        @(negedge clk);
        chk("no_extra_accept", 48'(busy1), 48'(0));

        // reset during the 4th read, then the FIPS vector again
        in_valid1 = 1'b1; r_in1 = fips_r; k_in1 = fips_k;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("read3_before_rst", 48'({sbox_req1, sbox_sel1}), 48'({1'b1, 3'd3}));
        rst = 1'b1;
        #1;
        chk("abort_in_ready", 48'(in_ready1), 48'(1));
        chk("abort_out_valid", 48'(out_valid1), 48'(0));
        chk("abort_busy", 48'(busy1), 48'(0));
        chk("abort_rom_if", 48'({sbox_req1, sbox_sel1, sbox_addr1}), 48'(0));
        chk("abort_f_out", 48'(f_out1), 48'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        @(negedge clk);
        wait_vld1(n);
        chk("post_rst_latency", 48'(n), 48'(9));
        chk("post_rst_f_out", 48'(f_out1), 48'(fips_f));
        @(posedge clk);
        @(negedge clk);

        // all-zero operand: every read at address 0
        in_valid1 = 1'b1; r_in1 = '0; k_in1 = '0;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("zero_read", 48'({sbox_req1, sbox_sel1, sbox_addr1}), 48'({1'b1, 3'(i), 6'd0}));
            @(posedge clk);
        end
        @(negedge clk);
        chk("no_read_after_8", 48'({sbox_req1, sbox_sel1, sbox_addr1}), 48'(0));
        wait_vld1(n);
        chk("zero_latency", 48'(8 + n), 48'(9));
        chk("zero_f_out", 48'(f_out1), 48'(zero_f));
        @(posedge clk);
        @(negedge clk);

        // FIPS vector through the two-cycle ROM
        in_valid2 = 1'b1; r_in2 = fips_r; k_in2 = fips_k;
        @(posedge clk); #1;
        in_valid2 = 1'b0; r_in2 = '0; k_in2 = '0;
        @(negedge clk);
        wait_vld2(n);
        chk("lat2_latency", 48'(n), 48'(10));
        chk("lat2_f_out", 48'(f_out2), 48'(fips_f));
        @(posedge clk);
        @(negedge clk);
        chk("lat2_pulse", 48'(out_valid2), 48'(0));
        chk("lat2_in_ready", 48'(in_ready2), 48'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end

endmodule
